// File: rtl/rv32_ctrl_pkg.sv
// Control encodings and the ID/EX bundle shared by the RV32 decode/execute slice.
package rv32_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    BC_NONE = 2'b00,
    BCB     = 2'b01,
    BCJAL   = 2'b10,
    BCJALR  = 2'b11
  } branch_e;

  typedef enum logic [1:0] {
    M2R_ALU = 2'b00,
    M2R_MEM = 2'b01,
    M2R_PC4 = 2'b10
  } mem2reg_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

  typedef struct packed {
    logic     alu_src;
    mem2reg_e mem2reg;
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    branch_e  branch;
    alu_op_e  alu_op;
  } ctrl_t;

  // Branch is resolved in ID, so it is not carried into EX.
  typedef struct packed {
    logic            alu_src;
    mem2reg_e        mem2reg;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    alu_op_e         alu_op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic            funct7_5;
    logic [2:0]      funct3;
    logic [4:0]      rd;
  } id_ex_t;

endpackage

// File: rtl/rv32_alu.sv
// Combinational EX-stage ALU: ALU control decode plus arithmetic.
// Shifter is built only when ALU_SHIFT_EN is defined; otherwise shift codes yield 0.
module rv32_alu
  import rv32_ctrl_pkg::*;
(
  input  alu_op_e          alu_op,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             alu_src,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  imm,
  output alu_ctrl_e        alu_ctrl,
  output logic [XLEN-1:0]  result,
  output logic             zero
);

  logic [XLEN-1:0]        op_b;
  logic signed [XLEN-1:0] op_a_s;
  logic signed [XLEN-1:0] op_b_s;

  assign op_b   = alu_src ? imm : rs2;
  assign op_a_s = rs1;
  assign op_b_s = op_b;

  // I-type arithmetic has no SUB form, so funct7_5 only selects SUB for R-type.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_ctrl = (alu_op == ALUOP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
    endcase
  end

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_AND:  result = rs1 & op_b;
      ALU_OR:   result = rs1 | op_b;
      ALU_ADD:  result = rs1 + op_b;
      ALU_XOR:  result = rs1 ^ op_b;
      ALU_SUB:  result = rs1 - op_b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (rs1 < op_b)};
`ifdef ALU_SHIFT_EN
      ALU_SLL:  result = rs1 << op_b[4:0];
      ALU_SRL:  result = rs1 >> op_b[4:0];
      ALU_SRA:  result = op_a_s >>> op_b[4:0];
`else
      ALU_SLL:  result = '0;
      ALU_SRL:  result = '0;
      ALU_SRA:  result = '0;
`endif
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rv32_decode_exec_unit.sv
// Decode-to-execute slice of the RV32 pipeline: main decode, ID/EX register and EX ALU.
// Optional shifter enabled with ALU_SHIFT_EN.
module rv32_decode_exec_unit
  import rv32_ctrl_pkg::*;
(
  input  logic             clockCPU,
  input  logic             reset,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [XLEN-1:0]  imm_i,
  output logic [1:0]       id_branch_o,
  output logic [XLEN-1:0]  alu_result_o,
  output logic             alu_zero_o,
  output logic [XLEN-1:0]  store_data_o,
  output logic [1:0]       ex_mem2reg_o,
  output logic             ex_regwrite_o,
  output logic             ex_memread_o,
  output logic             ex_memwrite_o,
  output logic [4:0]       ex_rd_o,
  output logic [3:0]       alu_ctrl_o
);

  ctrl_t     id_ctrl;
  id_ex_t    id_ex;
  alu_ctrl_e ex_alu_ctrl;
  logic      unused_instr_bits;

  assign unused_instr_bits = ^{instr_i[31], instr_i[29:15]};

  // Unknown opcodes decode to an all-zero bubble with no side effects.
  always_comb begin
    id_ctrl = '0;
    case (instr_i[6:0])
      OP_R:      id_ctrl = '{alu_src: 1'b0, mem2reg: M2R_ALU, reg_write: 1'b1, mem_read: 1'b0,
                             mem_write: 1'b0, branch: BC_NONE, alu_op: ALUOP_RTYPE};
      OP_I_ALU:  id_ctrl = '{alu_src: 1'b1, mem2reg: M2R_ALU, reg_write: 1'b1, mem_read: 1'b0,
                             mem_write: 1'b0, branch: BC_NONE, alu_op: ALUOP_ITYPE};
      OP_LOAD:   id_ctrl = '{alu_src: 1'b1, mem2reg: M2R_MEM, reg_write: 1'b1, mem_read: 1'b1,
                             mem_write: 1'b0, branch: BC_NONE, alu_op: ALUOP_ADD};
      OP_STORE:  id_ctrl = '{alu_src: 1'b1, mem2reg: M2R_ALU, reg_write: 1'b0, mem_read: 1'b0,
                             mem_write: 1'b1, branch: BC_NONE, alu_op: ALUOP_ADD};
      OP_BRANCH: id_ctrl = '{alu_src: 1'b0, mem2reg: M2R_ALU, reg_write: 1'b0, mem_read: 1'b0,
                             mem_write: 1'b0, branch: BCB, alu_op: ALUOP_SUB};
      OP_JAL:    id_ctrl = '{alu_src: 1'b0, mem2reg: M2R_PC4, reg_write: 1'b1, mem_read: 1'b0,
                             mem_write: 1'b0, branch: BCJAL, alu_op: ALUOP_ADD};
      OP_JALR:   id_ctrl = '{alu_src: 1'b1, mem2reg: M2R_PC4, reg_write: 1'b1, mem_read: 1'b0,
                             mem_write: 1'b0, branch: BCJALR, alu_op: ALUOP_ADD};
      default:   id_ctrl = '0;
    endcase
  end

  assign id_branch_o = id_ctrl.branch;

  always_ff @(posedge clockCPU or posedge reset) begin
    if (reset) begin
      id_ex <= '0;
    end else begin
      id_ex <= '{alu_src:   id_ctrl.alu_src,
                 mem2reg:   id_ctrl.mem2reg,
                 reg_write: id_ctrl.reg_write,
                 mem_read:  id_ctrl.mem_read,
                 mem_write: id_ctrl.mem_write,
                 alu_op:    id_ctrl.alu_op,
                 rs1:       rs1_data_i,
                 rs2:       rs2_data_i,
                 imm:       imm_i,
                 funct7_5:  instr_i[30],
                 funct3:    instr_i[14:12],
                 rd:        instr_i[11:7]};
    end
  end

  rv32_alu u_alu (
    .alu_op   (id_ex.alu_op),
    .funct3   (id_ex.funct3),
    .funct7_5 (id_ex.funct7_5),
    .alu_src  (id_ex.alu_src),
    .rs1      (id_ex.rs1),
    .rs2      (id_ex.rs2),
    .imm      (id_ex.imm),
    .alu_ctrl (ex_alu_ctrl),
    .result   (alu_result_o),
    .zero     (alu_zero_o)
  );

  assign alu_ctrl_o    = ex_alu_ctrl;
  assign store_data_o  = id_ex.rs2;
  assign ex_mem2reg_o  = id_ex.mem2reg;
  assign ex_regwrite_o = id_ex.reg_write;
  assign ex_memread_o  = id_ex.mem_read;
  assign ex_memwrite_o = id_ex.mem_write;
  assign ex_rd_o       = id_ex.rd;

endmodule

// File: tb/tb_rv32_decode_exec_unit.sv
// Self-checking bench for rv32_decode_exec_unit: directed cases plus randomized
// instructions against a behavioural model of decode and ALU (honours ALU_SHIFT_EN).
module tb_rv32_decode_exec_unit;

  logic        clockCPU;
  logic        reset;
  logic [31:0] instr_i, rs1_data_i, rs2_data_i, imm_i;
  logic [1:0]  id_branch_o;
  logic [31:0] alu_result_o;
  logic        alu_zero_o;
  logic [31:0] store_data_o;
  logic [1:0]  ex_mem2reg_o;
  logic        ex_regwrite_o, ex_memread_o, ex_memwrite_o;
  logic [4:0]  ex_rd_o;
  logic [3:0]  alu_ctrl_o;

  int errors = 0;
  int checks = 0;

  // Values that the next rising edge (or the last one) latched into ID/EX.
  logic [31:0] p_instr, p_rs1, p_rs2, p_imm;

`ifdef ALU_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  rv32_decode_exec_unit dut (
    .clockCPU      (clockCPU),
    .reset         (reset),
    .instr_i       (instr_i),
    .rs1_data_i    (rs1_data_i),
    .rs2_data_i    (rs2_data_i),
    .imm_i         (imm_i),
    .id_branch_o   (id_branch_o),
    .alu_result_o  (alu_result_o),
    .alu_zero_o    (alu_zero_o),
    .store_data_o  (store_data_o),
    .ex_mem2reg_o  (ex_mem2reg_o),
    .ex_regwrite_o (ex_regwrite_o),
    .ex_memread_o  (ex_memread_o),
    .ex_memwrite_o (ex_memwrite_o),
    .ex_rd_o       (ex_rd_o),
    .alu_ctrl_o    (alu_ctrl_o)
  );

  initial begin
    clockCPU = 1'b0;
    forever #5 clockCPU = ~clockCPU;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: instruction semantics straight from the control table and ALU rules.
  function automatic void model(input logic [31:0] instr, rs1, rs2, imm,
                                output logic [1:0] br, output logic [1:0] m2r,
                                output logic rw, output logic mr, output logic mw,
                                output logic [3:0] code, output logic [31:0] res);
    logic             src;
    logic [1:0]       aop;
    logic [31:0]      b;
    logic signed [31:0] sa, sb;
    logic [10:0]      row;
    case (instr[6:0])
      7'b0110011: row = 11'b0_00_1_0_0_00_10;
      7'b0010011: row = 11'b1_00_1_0_0_00_11;
      7'b0000011: row = 11'b1_01_1_1_0_00_00;
      7'b0100011: row = 11'b1_00_0_0_1_00_00;
      7'b1100011: row = 11'b0_00_0_0_0_01_01;
      7'b1101111: row = 11'b0_10_1_0_0_10_00;
      7'b1100111: row = 11'b1_10_1_0_0_11_00;
      default:    row = 11'b0;
    endcase
    {src, m2r, rw, mr, mw, br, aop} = row;
    b  = src ? imm : rs2;
    sa = rs1;
    sb = b;
    if (aop == 2'b00)      code = 4'b0010;
    else if (aop == 2'b01) code = 4'b0110;
    else begin
      case (instr[14:12])
        3'd0: code = (aop == 2'b10 && instr[30]) ? 4'b0110 : 4'b0010;
        3'd1: code = 4'b0100;
        3'd2: code = 4'b0111;
        3'd3: code = 4'b1001;
        3'd4: code = 4'b0011;
        3'd5: code = instr[30] ? 4'b1000 : 4'b0101;
        3'd6: code = 4'b0001;
        default: code = 4'b0000;
      endcase
    end
    case (code)
      4'b0000: res = rs1 & b;
      4'b0001: res = rs1 | b;
      4'b0010: res = rs1 + b;
      4'b0011: res = rs1 ^ b;
      4'b0110: res = rs1 - b;
      4'b0111: res = (sa < sb) ? 32'd1 : 32'd0;
      4'b1001: res = (rs1 < b) ? 32'd1 : 32'd0;
      4'b0100: res = SHIFT_EN ? rs1 << b[4:0] : 32'd0;
      4'b0101: res = SHIFT_EN ? rs1 >> b[4:0] : 32'd0;
      4'b1000: res = SHIFT_EN ? 32'(sa >>> b[4:0]) : 32'd0;
      default: res = 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string tag);
    logic [1:0] br, m2r;
    logic rw, mr, mw;
    logic [3:0] code;
    logic [31:0] res;
    model(p_instr, p_rs1, p_rs2, p_imm, br, m2r, rw, mr, mw, code, res);
    check({tag, ".regwrite"}, 32'(ex_regwrite_o), 32'(rw));
    check({tag, ".memread"},  32'(ex_memread_o),  32'(mr));
    check({tag, ".memwrite"}, 32'(ex_memwrite_o), 32'(mw));
    check({tag, ".mem2reg"},  32'(ex_mem2reg_o),  32'(m2r));
    check({tag, ".rd"},       32'(ex_rd_o),       32'(p_instr[11:7]));
    check({tag, ".store"},    store_data_o,       p_rs2);
    check({tag, ".aluctrl"},  32'(alu_ctrl_o),    32'(code));
    check({tag, ".result"},   alu_result_o,       res);
    check({tag, ".zero"},     32'(alu_zero_o),    32'(res == 32'd0));
  endtask

  // Called just after a falling edge; returns at the next falling edge with EX outputs checked.
  task automatic applyStimulus(input string tag, input logic [31:0] instr, rs1, rs2, imm);
    logic [1:0] br, m2r;
    logic rw, mr, mw;
    logic [3:0] code;
    logic [31:0] res;
    instr_i = instr; rs1_data_i = rs1; rs2_data_i = rs2; imm_i = imm;
    #1;
    model(instr, rs1, rs2, imm, br, m2r, rw, mr, mw, code, res);
    check({tag, ".id_branch"}, 32'(id_branch_o), 32'(br));
    p_instr = instr; p_rs1 = rs1; p_rs2 = rs2; p_imm = imm;
    @(negedge clockCPU);
    checkOutput(tag);
  endtask

  task automatic midReset();
    #2 reset = 1'b1;
    #1;
    check("async_rst.regwrite", 32'(ex_regwrite_o), 32'd0);
    check("async_rst.memread",  32'(ex_memread_o),  32'd0);
    check("async_rst.memwrite", 32'(ex_memwrite_o), 32'd0);
    check("async_rst.mem2reg",  32'(ex_mem2reg_o),  32'd0);
    check("async_rst.store",    store_data_o,       32'd0);
    check("async_rst.result",   alu_result_o,       32'd0);
    check("async_rst.zero",     32'(alu_zero_o),    32'd1);
    p_instr = '0; p_rs1 = '0; p_rs2 = '0; p_imm = '0;
    @(negedge clockCPU);
    checkOutput("rst_held");
    reset = 1'b0;
  endtask

  initial begin
    logic [6:0] ops [8];
    logic [31:0] r_instr, r_rs1, r_rs2, r_imm, t;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0000000};
    reset = 1'b1;
    instr_i = '0; rs1_data_i = '0; rs2_data_i = '0; imm_i = '0;
    p_instr = '0; p_rs1 = '0; p_rs2 = '0; p_imm = '0;
    @(negedge clockCPU);
    check("reset.result",  alu_result_o,       32'd0);
    check("reset.zero",    32'(alu_zero_o),    32'd1);
    check("reset.aluctrl", 32'(alu_ctrl_o),    32'h2);
    checkOutput("reset");
    reset = 1'b0;

    applyStimulus("add", 32'h0000_0033, 32'd5, 32'd7, 32'd0);
    check("add.lit_result",   alu_result_o,       32'd12);
    check("add.lit_regwrite", 32'(ex_regwrite_o), 32'd1);
    check("add.lit_ctrl",     32'(alu_ctrl_o),    32'h2);

    applyStimulus("sub", 32'h4000_0033, 32'd3, 32'd5, 32'd0);
    check("sub.lit_result", alu_result_o, 32'hFFFF_FFFE);
    applyStimulus("slt", 32'h0000_2033, 32'd3, 32'd5, 32'd0);
    check("slt.lit_result", alu_result_o, 32'd1);
    applyStimulus("sltu", 32'h0000_3033, 32'd3, 32'd5, 32'd0);
    check("sltu.lit_result", alu_result_o, 32'd1);
    applyStimulus("slt_neg", 32'h0000_2033, 32'hFFFF_FFFF, 32'd1, 32'd0);
    check("slt_neg.lit_result", alu_result_o, 32'd1);

    applyStimulus("lw", 32'h0000_2083, 32'h100, 32'h55, 32'd8);
    check("lw.lit_result",  alu_result_o,       32'h108);
    check("lw.lit_memread", 32'(ex_memread_o),  32'd1);
    check("lw.lit_mem2reg", 32'(ex_mem2reg_o),  32'd1);
    check("lw.lit_rd",      32'(ex_rd_o),       32'd1);

    applyStimulus("sw", 32'h0000_2023, 32'h100, 32'hDEAD_BEEF, 32'd4);
    check("sw.lit_memwrite", 32'(ex_memwrite_o), 32'd1);
    check("sw.lit_store",    store_data_o,       32'hDEAD_BEEF);
    check("sw.lit_regwrite", 32'(ex_regwrite_o), 32'd0);
    check("sw.lit_result",   alu_result_o,       32'h104);

    applyStimulus("beq", 32'h0000_0063, 32'd9, 32'd9, 32'h10);
    check("beq.lit_branch", 32'(id_branch_o), 32'd1);
    check("beq.lit_zero",   32'(alu_zero_o),  32'd1);

    applyStimulus("jalr", 32'h0000_00E7, 32'h200, 32'd0, 32'd4);
    check("jalr.lit_branch",  32'(id_branch_o),  32'd3);
    check("jalr.lit_mem2reg", 32'(ex_mem2reg_o), 32'd2);

    applyStimulus("srai", 32'h4000_5013, 32'h8000_0000, 32'd0, 32'h404);
    check("srai.lit_result", alu_result_o, SHIFT_EN ? 32'hF800_0000 : 32'd0);

    applyStimulus("bad_op", 32'hFFFF_FFFF, 32'd1, 32'd2, 32'd3);
    check("bad_op.lit_regwrite", 32'(ex_regwrite_o), 32'd0);
    check("bad_op.lit_memwrite", 32'(ex_memwrite_o), 32'd0);
    check("bad_op.lit_branch",   32'(id_branch_o),   32'd0);

    applyStimulus("pre_rst", 32'h0000_0033, 32'd40, 32'd2, 32'd0);
    midReset();

    for (int i = 0; i < 400; i++) begin
      r_instr = $urandom;
      r_instr[6:0] = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 6)];
      r_rs1 = $urandom;
      case ($urandom_range(0, 3))
        0: r_rs2 = r_rs1;
        1: r_rs2 = $urandom_range(0, 40);
        default: r_rs2 = $urandom;
      endcase
      t = $urandom;
      r_imm = ($urandom_range(0, 3) == 0) ? r_rs1 : {{20{t[11]}}, t[11:0]};
      applyStimulus("rand", r_instr, r_rs1, r_rs2, r_imm);
      if (i == 200) midReset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
